// File: rtl/btn_cmd_gen.sv
// btn_cmd_gen: sync, debounce and arbitrate three pushbuttons into held one-hot Processor commands.
// Define AUTO_REPEAT_EN to re-issue a held command every REPEAT_CYCLES.
module btn_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES = 2,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_n_raw,
  input  logic [7:0] sw,
  output logic [2:0] btn,
  output logic [7:0] bytePos,
  output logic       cmd_valid
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;
  state_t state;
  logic [2:0] s1, s2, deb, deb_d, lvl, ev, win;
  logic [DW-1:0] cnt [3];
  logic [HW-1:0] hcnt;
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  logic [RW-1:0] rcnt;
  logic [2:0] cmd;
`endif
  assign lvl = ~s2;
  assign ev = deb & ~deb_d;
  assign win = ev[2] ? 3'b100 : ev[1] ? 3'b010 : ev[0] ? 3'b001 : 3'b000;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '1;
      s2 <= '1;
      deb <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_n_raw;
      s2 <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++)
        if (lvl[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      btn <= '0;
      bytePos <= '0;
      cmd_valid <= 1'b0;
      hcnt <= '0;
`ifdef AUTO_REPEAT_EN
      rcnt <= '0;
      cmd <= '0;
`endif
    end else begin
      case (state)
        IDLE:
          if (|ev) begin
            btn <= win;
            bytePos <= sw;
            cmd_valid <= 1'b1;
            hcnt <= HW'(HOLD_CYCLES - 1);
            state <= HOLD;
`ifdef AUTO_REPEAT_EN
            cmd <= win;
`endif
          end
        HOLD: begin
          cmd_valid <= 1'b0;
          if (hcnt == '0) begin
            btn <= '0;
            state <= WAIT_REL;
          end else hcnt <= hcnt - 1'b1;
        end
        WAIT_REL: begin
`ifdef AUTO_REPEAT_EN
          if (|(deb & cmd)) begin
            if (rcnt == RW'(REPEAT_CYCLES - 1)) begin
              rcnt <= '0;
              btn <= cmd;
              bytePos <= sw;
              cmd_valid <= 1'b1;
              hcnt <= HW'(HOLD_CYCLES - 1);
              state <= HOLD;
            end else rcnt <= rcnt + 1'b1;
          end else begin
            rcnt <= '0;
            if (deb == 3'b000) state <= IDLE;
          end
`else
          if (deb == 3'b000) state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_btn_cmd_gen.sv
// tb_btn_cmd_gen: scoreboard bench; stimulus queues expected commands, a negedge monitor checks them.
module tb_btn_cmd_gen;
  localparam int D = 4, H = 2, R = 20;
  logic clk = 0, rst = 0;
  logic [2:0] btn_n_raw = 3'b000;
  logic [7:0] sw = 8'hff;
  logic [2:0] btn;
  logic [7:0] bytePos;
  logic cmd_valid;
  int checks = 0, errors = 0, cyc = 0, pend = 0;
  logic [2:0] cur = '0;
  typedef struct { logic [2:0] b; logic [7:0] p; int c; } exp_t;
  exp_t q[$];

  btn_cmd_gen #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .btn_n_raw(btn_n_raw), .sw(sw),
    .btn(btn), .bytePos(bytePos), .cmd_valid(cmd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic wn(int n);
    repeat (n) @(negedge clk);
  endtask

  // Command lands 2 sync + D debounce + 1 FSM edges after the input changes.
  task automatic push(logic [2:0] b, logic [7:0] p);
    exp_t e;
    e.b = b;
    e.p = p;
    e.c = cyc + D + 3;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) pend = 0;
    else if (cmd_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got btn=%b bytePos=%0d, required no command", btn, bytePos);
      end else begin
        e = q.pop_front();
        check("cmd_btn", int'(btn), int'(e.b));
        check("cmd_bytePos", int'(bytePos), int'(e.p));
        check("cmd_cycle", cyc, e.c);
      end
      pend = H - 1;
      cur = btn;
    end else if (pend > 0) begin
      check("hold_btn", int'(btn), int'(cur));
      pend--;
    end else check("idle_btn", int'(btn), 0);
  end

  initial begin
    #1;
    check("rst_btn", int'(btn), 0);
    check("rst_bytePos", int'(bytePos), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    #1 btn_n_raw = 3'b111; sw = 8'h00;
    #1 rst = 1;
    wn(3);
    sw = 50; btn_n_raw = 3'b011; push(3'b100, 50);
    wn(20); btn_n_raw = 3'b111; wn(15);
    btn_n_raw = 3'b110; wn(2); btn_n_raw = 3'b111; wn(15);
    sw = 7; btn_n_raw = 3'b100; push(3'b010, 7);
    wn(15); btn_n_raw = 3'b110;
    wn(15); btn_n_raw = 3'b111; wn(15);
    sw = 0; btn_n_raw = 3'b110; push(3'b001, 0);
    wn(10); btn_n_raw = 3'b111; wn(12);
    sw = 9; btn_n_raw = 3'b101; push(3'b010, 9);
    wn(10); btn_n_raw = 3'b111; wn(15);
    sw = 8'hAA; wn(3);
    check("bytePos_idle", int'(bytePos), 9);
    sw = 33; btn_n_raw = 3'b011; push(3'b100, 33);
    wn(7);
    #1 rst = 0;
    #1;
    check("rst_hold_btn", int'(btn), 0);
    check("rst_hold_cmd_valid", int'(cmd_valid), 0);
    check("rst_hold_bytePos", int'(bytePos), 0);
    wn(1);
    #1 sw = 44; rst = 1; push(3'b100, 44);
    wn(20); btn_n_raw = 3'b111; wn(20);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required finish before 200000 ns");
    $fatal(1);
  end
endmodule
